mem_stage_ctrl: RTL

// - MEM-stage consumer of the EX/MEM latch: turns latched load/store controls into a dcache request (dREN/dWEN/daddr/dstore).
// - Waits for dhit, stalls the pipeline while an access is outstanding and captures load data.
// - Delivers a one-cycle-valid result beat toward the MEM/WB latch; handles halt drain and flush.

---
 rtl/mem_stage_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage dcache sequencer: request, stall, result beat, halt drain, watchdog.
// Define LLSC_EN to add the LL/SC link register with snoop invalidation.
module mem_stage_ctrl #(
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              em_valid,
   input  logic              MemWr_out,
   input  logic              MemtoReg_out,
   input  logic              is_ll,
   input  logic              is_sc,
   input  logic              halt_out,
   input  logic              flush,
   input  logic [WORD_W-1:0] ALUOut_out,
   input  logic [WORD_W-1:0] rdat2_out,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dload,
   input  logic              snoop_inv,
   input  logic [WORD_W-1:0] snoop_addr,
   output logic              dREN,
   output logic              dWEN,
   output logic [WORD_W-1:0] daddr,
   output logic [WORD_W-1:0] dstore,
   output logic              mem_stall,
   output logic              wb_valid,
   output logic [WORD_W-1:0] wb_data,
   output logic              halt_done,
   output logic              misalign,
   output logic              err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t            state, state_d;
   logic              dren_d, dwen_d;
   logic [WORD_W-1:0] daddr_d, dstore_d, wbd_d;
   logic              wbv_d, mis_d, haltd_d, err_d;
   logic              mis_q, mis_qd;
   logic              ld_q, ld_qd;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              mem_op, req, mis_in;
   logic [WORD_W-1:0] addr_in;

   assign mem_op  = MemWr_out | MemtoReg_out;
   assign req     = em_valid & ~flush & ~halt_done & mem_op;
   assign addr_in = {ALUOut_out[WORD_W-1:2], 2'b00};
   assign mis_in  = |ALUOut_out[1:0];

   assign mem_stall = ((state == IDLE) && req) || (state == REQ);

`ifdef LLSC_EN
   logic              link_v, link_v_d;
   logic [WORD_W-1:0] link_a, link_a_d;
   logic              ll_q, ll_qd;
   logic              sc_ok, snoop_hit;

   assign sc_ok     = link_v & (link_a == addr_in);
   assign snoop_hit = snoop_inv & link_v &
                      (snoop_addr[WORD_W-1:2] == link_a[WORD_W-1:2]);
`else
   logic unused_llsc;
   assign unused_llsc = &{1'b0, is_ll, is_sc, snoop_inv, snoop_addr};
`endif

   always_comb begin
      state_d  = state;
      dren_d   = dREN;
      dwen_d   = dWEN;
      daddr_d  = daddr;
      dstore_d = dstore;
      wbv_d    = 1'b0;
      wbd_d    = wb_data;
      mis_d    = 1'b0;
      haltd_d  = halt_done;
      err_d    = err;
      mis_qd   = mis_q;
      ld_qd    = ld_q;
      cnt_d    = cnt;
`ifdef LLSC_EN
      link_v_d = link_v;
      link_a_d = link_a;
      ll_qd    = ll_q;
      if (snoop_hit) link_v_d = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            if (req) begin
               daddr_d  = addr_in;
               dstore_d = rdat2_out;
               mis_qd   = mis_in;
               ld_qd    = MemtoReg_out;
               dren_d   = MemtoReg_out;
               dwen_d   = MemWr_out;
               state_d  = REQ;
`ifdef LLSC_EN
               ll_qd = is_ll & MemtoReg_out;
               if (MemWr_out && (is_sc || sc_ok)) link_v_d = 1'b0;
               // failed SC never touches the dcache
               if (MemWr_out && is_sc && !sc_ok) begin
                  dren_d  = 1'b0;
                  dwen_d  = 1'b0;
                  state_d = DONE;
                  wbv_d   = 1'b1;
                  wbd_d   = '0;
                  mis_d   = mis_in;
               end
`endif
            end else if (em_valid && !flush && !halt_done) begin
               if (halt_out) begin
                  haltd_d = 1'b1;
               end else begin
                  wbv_d = 1'b1;
                  wbd_d = '0;
               end
            end
         end
         REQ: begin
            if (dhit) begin
               dren_d  = 1'b0;
               dwen_d  = 1'b0;
               state_d = DONE;
               wbv_d   = 1'b1;
               mis_d   = mis_q;
               wbd_d   = ld_q ? dload : WORD_W'(1);
`ifdef LLSC_EN
               if (ll_q) begin
                  link_v_d = 1'b1;
                  link_a_d = daddr;
               end
`endif
            end else if (TIMEOUT != 0) begin
               if (cnt == CNT_W'(TIMEOUT - 1)) err_d = 1'b1;
               else cnt_d = cnt + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         dREN      <= 1'b0;
         dWEN      <= 1'b0;
         daddr     <= '0;
         dstore    <= '0;
         wb_valid  <= 1'b0;
         wb_data   <= '0;
         misalign  <= 1'b0;
         halt_done <= 1'b0;
         err       <= 1'b0;
         mis_q     <= 1'b0;
         ld_q      <= 1'b0;
         cnt       <= '0;
`ifdef LLSC_EN
         link_v    <= 1'b0;
         link_a    <= '0;
         ll_q      <= 1'b0;
`endif
      end else begin
         state     <= state_d;
         dREN      <= dren_d;
         dWEN      <= dwen_d;
         daddr     <= daddr_d;
         dstore    <= dstore_d;
         wb_valid  <= wbv_d;
         wb_data   <= wbd_d;
         misalign  <= mis_d;
         halt_done <= haltd_d;
         err       <= err_d;
         mis_q     <= mis_qd;
         ld_q      <= ld_qd;
         cnt       <= cnt_d;
`ifdef LLSC_EN
         link_v    <= link_v_d;
         link_a    <= link_a_d;
         ll_q      <= ll_qd;
`endif
      end
   end

endmodule
